beam_sweep_controller: RTL and testbench

BEAM_SWEEP_CONTROLLER -- requirements
Module: beam_sweep_controller

---
 rtl/beam_sweep_controller.sv | 206 ++++++++++++++++++++
 tb/tb_beam_sweep_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/beam_sweep_controller.sv
// beam_sweep_controller
//   Steps a four-mic delay-and-sum beamformer through NUM_ANGLES steering
//   angles. At each angle it discards SETTLE_SAMPLES valid samples and then
//   integrates |sample| over DWELL_SAMPLES valid samples. At the end of the
//   sweep it steers back to the angle with the highest energy.
//
// Ports
//   clk_in            system clock
//   rst_in            synchronous active-high reset
//   start_in          single-cycle pulse, begin a sweep (honoured in IDLE only)
//   beam_valid_in     delay-and-sum output sample valid
//   beam_audio_in     delay-and-sum output sample (signed)
//   delay_1..delay_4  per-mic delay in samples, to the delay-and-sum datapath
//   angle_out         angle index currently applied
//   busy_out          high while sweeping
//   done_out          one-cycle pulse at sweep end
//   best_angle_out    angle with the highest energy in the last sweep
//   best_energy_out   energy of that angle
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start_in; delays hold the best (or reset) angle
// SETTLE   | new delays applied, discarding valid samples
// DWELL    | integrating |sample| into the accumulator
// COMPARE  | one cycle: update best, then next angle or finish the sweep

module beam_sweep_controller #(
    parameter int BITS_AUDIO     = 24,
    parameter int NUM_ANGLES     = 16,
    parameter int STEP_SCALE     = 4,
    parameter int SETTLE_SAMPLES = 8,
    parameter int DWELL_SAMPLES  = 256
) (
    input  logic                                         clk_in,
    input  logic                                         rst_in,
    input  logic                                         start_in,
    input  logic                                         beam_valid_in,
    input  logic signed [BITS_AUDIO-1:0]                 beam_audio_in,
    output logic        [7:0]                            delay_1,
    output logic        [7:0]                            delay_2,
    output logic        [7:0]                            delay_3,
    output logic        [7:0]                            delay_4,
    output logic        [$clog2(NUM_ANGLES)-1:0]         angle_out,
    output logic                                         busy_out,
    output logic                                         done_out,
    output logic        [$clog2(NUM_ANGLES)-1:0]         best_angle_out,
    output logic [BITS_AUDIO+$clog2(DWELL_SAMPLES)-1:0]  best_energy_out
);

    localparam int A_W     = $clog2(NUM_ANGLES);
    localparam int E_W     = BITS_AUDIO + $clog2(DWELL_SAMPLES);
    localparam int CNT_MAX = (DWELL_SAMPLES > SETTLE_SAMPLES) ? DWELL_SAMPLES : SETTLE_SAMPLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [A_W-1:0]   ANGLE_CENTER = A_W'(NUM_ANGLES / 2);
    localparam logic [A_W-1:0]   ANGLE_LAST   = A_W'(NUM_ANGLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_SAMPLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD   = CNT_W'(DWELL_SAMPLES - 1);

    localparam logic signed [BITS_AUDIO-1:0] AUDIO_MIN = {1'b1, {(BITS_AUDIO-1){1'b0}}};
    localparam logic        [BITS_AUDIO-1:0] AUDIO_MAX = {1'b0, {(BITS_AUDIO-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_DWELL,
        S_COMPARE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [E_W-1:0]   acc;

    logic [BITS_AUDIO-1:0] mag;
    logic [E_W-1:0]        acc_next;
    logic                  acc_gt_best;
    logic [A_W-1:0]        best_angle_next;
    logic [A_W-1:0]        angle_inc;

    // Delay for one mic. Angles above centre steer toward mic 4 (mic 1 gets
    // zero delay); angles below centre mirror that.
    function automatic logic [7:0] calc_delay(input logic [A_W-1:0] angle, input int mic);
        int a;
        int c;
        int step;
        int mult;
        int d;
        a = int'(angle);
        c = NUM_ANGLES / 2;
        if (a >= c) begin
            step = (a - c) * STEP_SCALE;
            mult = mic - 1;
        end else begin
            step = (c - a) * STEP_SCALE;
            mult = 4 - mic;
        end
        d = mult * step;
        return (d > 255) ? 8'd255 : 8'(d);
    endfunction

    function automatic logic [31:0] delay_set(input logic [A_W-1:0] angle);
        return {calc_delay(angle, 1), calc_delay(angle, 2),
                calc_delay(angle, 3), calc_delay(angle, 4)};
    endfunction

    // Two's-complement negation of the most negative code wraps to itself,
    // so it is clamped to the largest positive magnitude instead.
    always_comb begin
        mag = '0;
        if (!beam_audio_in[BITS_AUDIO-1]) begin
            mag = unsigned'(beam_audio_in);
        end else if (beam_audio_in == AUDIO_MIN) begin
            mag = AUDIO_MAX;
        end else begin
            mag = unsigned'(-beam_audio_in);
        end
    end

    // The accumulator is sized so DWELL_SAMPLES maximal magnitudes cannot wrap.
    always_comb begin
        acc_next        = acc + E_W'(mag);
        acc_gt_best     = (acc > best_energy_out);
        best_angle_next = acc_gt_best ? angle_out : best_angle_out;
        angle_inc       = angle_out + 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= S_IDLE;
            cnt             <= '0;
            acc             <= '0;
            angle_out       <= ANGLE_CENTER;
            delay_1         <= 8'd0;
            delay_2         <= 8'd0;
            delay_3         <= 8'd0;
            delay_4         <= 8'd0;
            busy_out        <= 1'b0;
            done_out        <= 1'b0;
            best_angle_out  <= ANGLE_CENTER;
            best_energy_out <= '0;
        end else begin
            done_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    // done_out is still high in the first IDLE cycle; a start
                    // coinciding with it is dropped.
                    if (start_in && !done_out) begin
                        state           <= S_SETTLE;
                        angle_out       <= '0;
                        {delay_1, delay_2, delay_3, delay_4} <= delay_set('0);
                        best_angle_out  <= '0;
                        best_energy_out <= '0;
                        busy_out        <= 1'b1;
                        cnt             <= SETTLE_LOAD;
                        acc             <= '0;
                    end
                end

                S_SETTLE: begin
                    if (beam_valid_in) begin
                        if (cnt == '0) begin
                            state <= S_DWELL;
                            cnt   <= DWELL_LOAD;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end

                S_DWELL: begin
                    if (beam_valid_in) begin
                        acc <= acc_next;
                        if (cnt == '0) begin
                            state <= S_COMPARE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end

                S_COMPARE: begin
                    if (acc_gt_best) begin
                        best_energy_out <= acc;
                        best_angle_out  <= angle_out;
                    end
                    acc <= '0;
                    if (angle_out == ANGLE_LAST) begin
                        angle_out <= best_angle_next;
                        {delay_1, delay_2, delay_3, delay_4} <= delay_set(best_angle_next);
                        done_out  <= 1'b1;
                        busy_out  <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        angle_out <= angle_inc;
                        {delay_1, delay_2, delay_3, delay_4} <= delay_set(angle_inc);
                        cnt       <= SETTLE_LOAD;
                        state     <= S_SETTLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_beam_sweep_controller.sv
// tb_beam_sweep_controller
//   Directed sweeps from a scenario table against a cycle model of sample
//   counting, plus reset, stall and start-masking sequences. A second
//   instance with STEP_SCALE=40 covers delay saturation.

module tb_beam_sweep_controller;

    localparam int NA = 16;

    logic               clk_in = 1'b0;
    logic               rst_in = 1'b1;
    logic               start_in = 1'b0;
    logic               beam_valid_in = 1'b0;
    logic signed [23:0] beam_audio_in = '0;
    logic [7:0]         delay_1, delay_2, delay_3, delay_4;
    logic [3:0]         angle_out, best_angle_out;
    logic               busy_out, done_out;
    logic [31:0]        best_energy_out;

    logic               start_s = 1'b0;
    logic               valid_s = 1'b0;
    logic [7:0]         s_d1, s_d2, s_d3, s_d4;
    logic [3:0]         s_angle, s_best_angle;
    logic               s_busy, s_done;
    logic [31:0]        s_best_energy;

    always #5 clk_in = ~clk_in;

    beam_sweep_controller dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .start_in        (start_in),
        .beam_valid_in   (beam_valid_in),
        .beam_audio_in   (beam_audio_in),
        .delay_1         (delay_1),
        .delay_2         (delay_2),
        .delay_3         (delay_3),
        .delay_4         (delay_4),
        .angle_out       (angle_out),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .best_angle_out  (best_angle_out),
        .best_energy_out (best_energy_out)
    );

    beam_sweep_controller #(.STEP_SCALE(40)) dut_s (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .start_in        (start_s),
        .beam_valid_in   (valid_s),
        .beam_audio_in   (24'sd0),
        .delay_1         (s_d1),
        .delay_2         (s_d2),
        .delay_3         (s_d3),
        .delay_4         (s_d4),
        .angle_out       (s_angle),
        .busy_out        (s_busy),
        .done_out        (s_done),
        .best_angle_out  (s_best_angle),
        .best_energy_out (s_best_energy)
    );

    typedef struct {
        int     period;
        int     hot_angle;
        int     hot_amp;
        int     base_amp;
        int     stall_angle;
        int     abort_angle;
        int     exp_angle;
        longint exp_energy;
    } scen_t;

    scen_t       scen[5];
    logic [31:0] dly_tbl[NA];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [37:0] snap();
        return {angle_out, busy_out, done_out, delay_1, delay_2, delay_3, delay_4};
    endfunction

    function automatic logic [37:0] exp_snap(input int a, input logic busy, input logic done);
        return {4'(a), busy, done, dly_tbl[a]};
    endfunction

    task automatic run_sweep(input scen_t s);
        int m_angle, m_cnt, cyc, stall_left;
        bit m_cmp, fin, stall_a, stall_b, v;
        m_angle = 0; m_cnt = 0; cyc = 0; stall_left = 0;
        m_cmp = 0; fin = 0; stall_a = 0; stall_b = 0;

        start_in = 1'b1; beam_valid_in = 1'b0;
        @(posedge clk_in); #1;
        start_in = 1'b0;
        chk("start_state", snap(), exp_snap(0, 1'b1, 1'b0));
        chk("best_cleared", {best_angle_out, best_energy_out}, 36'd0);

        while (!fin && cyc < 4300 * s.period + 3000) begin
            if (m_angle == s.abort_angle && m_cnt == 100) begin
                rst_in = 1'b1; start_in = 1'b1; beam_valid_in = 1'b1;
                @(posedge clk_in); #1;
                chk("reset_state", snap(), exp_snap(8, 1'b0, 1'b0));
                chk("reset_best", {best_angle_out, best_energy_out}, {4'd8, 32'd0});
                rst_in = 1'b0; start_in = 1'b0; beam_valid_in = 1'b0;
                @(posedge clk_in); #1;
                chk("reset_idle", snap(), exp_snap(8, 1'b0, 1'b0));
                return;
            end
            if (m_angle == s.stall_angle && m_cnt == 3 && !stall_a) begin
                stall_a = 1; stall_left = 1000;
            end
            if (m_angle == s.stall_angle && m_cnt == 120 && !stall_b) begin
                stall_b = 1; stall_left = 1000;
            end
            v = (stall_left == 0) && (cyc % s.period == 0);
            if (stall_left > 0) stall_left--;
            beam_valid_in = v;
            beam_audio_in = (m_angle == s.hot_angle) ? 24'(s.hot_amp) : 24'(s.base_amp);
            start_in      = (cyc % 97 == 50);
            @(posedge clk_in);
            if (m_cmp) begin
                m_cmp = 0;
                if (m_angle == NA - 1) fin = 1;
                else m_angle++;
            end else if (v) begin
                m_cnt++;
                if (m_cnt == 264) begin
                    m_cnt = 0;
                    m_cmp = 1;
                end
            end
            cyc++;
            #1;
            if (fin) chk("sweep_end", snap(), exp_snap(s.exp_angle, 1'b0, 1'b1));
            else     chk("sweep_step", snap(), exp_snap(m_angle, 1'b1, 1'b0));
        end
        start_in = 1'b0; beam_valid_in = 1'b0;

        if (!fin) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout: no done_out after %0d cycles, expected one", cyc);
            return;
        end
        chk("best_angle", best_angle_out, s.exp_angle);
        chk("best_energy", best_energy_out, s.exp_energy);

        start_in = 1'b1;
        @(posedge clk_in); #1;
        start_in = 1'b0;
        chk("start_at_done_ignored", snap(), exp_snap(s.exp_angle, 1'b0, 1'b0));
    endtask

    initial begin
        // angle -> {delay_1, delay_2, delay_3, delay_4}, STEP_SCALE=4, centre 8
        dly_tbl[0]  = {8'd96, 8'd64, 8'd32, 8'd0};
        dly_tbl[1]  = {8'd84, 8'd56, 8'd28, 8'd0};
        dly_tbl[2]  = {8'd72, 8'd48, 8'd24, 8'd0};
        dly_tbl[3]  = {8'd60, 8'd40, 8'd20, 8'd0};
        dly_tbl[4]  = {8'd48, 8'd32, 8'd16, 8'd0};
        dly_tbl[5]  = {8'd36, 8'd24, 8'd12, 8'd0};
        dly_tbl[6]  = {8'd24, 8'd16, 8'd8,  8'd0};
        dly_tbl[7]  = {8'd12, 8'd8,  8'd4,  8'd0};
        dly_tbl[8]  = {8'd0,  8'd0,  8'd0,  8'd0};
        dly_tbl[9]  = {8'd0,  8'd4,  8'd8,  8'd12};
        dly_tbl[10] = {8'd0,  8'd8,  8'd16, 8'd24};
        dly_tbl[11] = {8'd0,  8'd12, 8'd24, 8'd36};
        dly_tbl[12] = {8'd0,  8'd16, 8'd32, 8'd48};
        dly_tbl[13] = {8'd0,  8'd20, 8'd40, 8'd60};
        dly_tbl[14] = {8'd0,  8'd24, 8'd48, 8'd72};
        dly_tbl[15] = {8'd0,  8'd28, 8'd56, 8'd84};

        //          period hot  hot_amp  base      stall abort best energy
        scen[0] = '{4,     -1,  0,       100,      -1,   -1,   0,   64'd25600};
        scen[1] = '{1,     5,   1000,    10,       -1,   7,    0,   64'd0};
        scen[2] = '{1,     5,   1000,    10,       3,    -1,   5,   64'd256000};
        scen[3] = '{1,     -1,  0,       -8388608, -1,   -1,   0,   64'd2147483392};
        scen[4] = '{2,     15,  -500,    3,        -1,   -1,   15,  64'd128000};

        rst_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        chk("por_state", snap(), exp_snap(8, 1'b0, 1'b0));
        chk("por_best", {best_angle_out, best_energy_out}, {4'd8, 32'd0});
        rst_in = 1'b0;

        start_s = 1'b1;
        @(posedge clk_in); #1;
        start_s = 1'b0;
        chk("scale40_angle0", {s_d1, s_d2, s_d3, s_d4}, {8'd255, 8'd255, 8'd255, 8'd0});
        chk("por_idle_kept", snap(), exp_snap(8, 1'b0, 1'b0));

        for (int i = 0; i < 5; i++) begin
            run_sweep(scen[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
